// File: rtl/id_ex_stage_reg_pkg.sv
// Shared decode/execute pipeline definitions: metadata layout and the
// occupancy states of the ID/EX register.
package id_ex_stage_reg_pkg;

  localparam int META_W = 82;

  // Bit positions inside the forwarded operand metadata word
  localparam int RS1_USED     = 81;
  localparam int RS1_MSB      = 80;
  localparam int RS1_DATA_MSB = 75;
  localparam int RS2_USED     = 43;
  localparam int RS2_MSB      = 42;
  localparam int RS2_DATA_MSB = 37;
  localparam int RD_USED      = 5;
  localparam int RD_MSB       = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, execute
// back-pressure hold, flush kill and saturating bubble/flush counters.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              id_valid_i,
  input  logic [META_W-1:0] id_meta_i,
  input  logic [31:0]       id_pc_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              load_use_stall_i,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              id_ready_o,
  output logic              ex_valid_o,
  output logic [META_W-1:0] ex_meta_o,
  output logic [31:0]       ex_pc_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  state_t state;
  logic   do_hold;
  logic   do_bubble;

  // Priority: flush beats hold, hold beats bubble, anything left advances
  always_comb begin
    do_hold    = 1'b0;
    do_bubble  = 1'b0;
    id_ready_o = 1'b1;
    if (!flush_i) begin
      if ((state == FULL) && !ex_ready_i) begin
        do_hold    = 1'b1;
        id_ready_o = 1'b0;
      end else if (id_valid_i && load_use_stall_i) begin
        do_bubble  = 1'b1;
        id_ready_o = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= EMPTY;
      ex_meta_o <= '0;
      ex_pc_o   <= '0;
      ex_ctrl_o <= '0;
    end else if (flush_i) begin
      state <= EMPTY;
    end else if (do_hold) begin
      state <= state;
    end else if (do_bubble) begin
      state <= EMPTY;
    end else begin
      state <= id_valid_i ? FULL : EMPTY;
      // Payload is left stale on an empty advance; it is ignored while invalid
      if (id_valid_i) begin
        ex_meta_o <= id_meta_i;
        ex_pc_o   <= id_pc_i;
        ex_ctrl_o <= id_ctrl_i;
      end
    end
  end

  assign ex_valid_o = (state == FULL);

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (do_bubble),
    .cnt_o  (bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (flush_i),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios followed by
// random traffic, all checked against a cycle-level reference model.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int CTRL_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [META_W-1:0] id_meta;
  logic [31:0]       id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic              load_use_stall;
  logic              flush;
  logic              ex_ready;
  logic              id_ready;
  logic              ex_valid;
  logic [META_W-1:0] ex_meta;
  logic [31:0]       ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Reference model of what execute should see
  bit                m_valid;
  logic [META_W-1:0] m_meta;
  logic [31:0]       m_pc;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_bub;
  int                m_fl;

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .id_valid_i       (id_valid),
    .id_meta_i        (id_meta),
    .id_pc_i          (id_pc),
    .id_ctrl_i        (id_ctrl),
    .load_use_stall_i (load_use_stall),
    .flush_i          (flush),
    .ex_ready_i       (ex_ready),
    .id_ready_o       (id_ready),
    .ex_valid_o       (ex_valid),
    .ex_meta_o        (ex_meta),
    .ex_pc_o          (ex_pc),
    .ex_ctrl_o        (ex_ctrl),
    .bubble_cnt_o     (bubble_cnt),
    .flush_cnt_o      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = flush, 1 = hold, 2 = bubble, 3 = advance
  function automatic int model_action();
    if (flush) return 0;
    if (m_valid && !ex_ready) return 1;
    if (id_valid && load_use_stall) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_meta  = '0;
    m_pc    = '0;
    m_ctrl  = '0;
    m_bub   = 0;
    m_fl    = 0;
  endtask

  task automatic model_edge();
    case (model_action())
      0: begin
        m_valid = 1'b0;
        m_fl    = (m_fl < CNT_MAX) ? m_fl + 1 : CNT_MAX;
      end
      1: ;
      2: begin
        m_valid = 1'b0;
        m_bub   = (m_bub < CNT_MAX) ? m_bub + 1 : CNT_MAX;
      end
      default: begin
        m_valid = id_valid;
        if (id_valid) begin
          m_meta = id_meta;
          m_pc   = id_pc;
          m_ctrl = id_ctrl;
        end
      end
    endcase
  endtask

  task automatic check_output(input string tag);
    cmp({tag, ".valid"},  128'(ex_valid),   128'(m_valid));
    cmp({tag, ".pc"},     128'(ex_pc),      128'(m_pc));
    cmp({tag, ".meta"},   128'(ex_meta),    128'(m_meta));
    cmp({tag, ".ctrl"},   128'(ex_ctrl),    128'(m_ctrl));
    cmp({tag, ".bubble"}, 128'(bubble_cnt), 128'(m_bub));
    cmp({tag, ".flush"},  128'(flush_cnt),  128'(m_fl));
  endtask

  function automatic logic [META_W-1:0] rand_meta();
    return {18'($urandom()), 32'($urandom()), 32'($urandom())};
  endfunction

  // Drive one cycle of inputs, check id_ready before the edge and the
  // registered outputs just after it
  task automatic apply_stimulus(input string tag, input logic v, input logic [META_W-1:0] meta,
                                input logic [31:0] pc, input logic stall, input logic fl,
                                input logic rdy);
    int act;
    id_valid       = v;
    id_meta        = meta;
    id_pc          = pc;
    id_ctrl        = CTRL_W'($urandom());
    load_use_stall = stall;
    flush          = fl;
    ex_ready       = rdy;
    #1;
    act = model_action();
    cmp({tag, ".id_ready"}, 128'(id_ready), 128'((act == 0) || (act == 3)));
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [META_W-1:0] meta;
    rst_n          = 1'b0;
    id_valid       = 1'b0;
    id_meta        = '0;
    id_pc          = '0;
    id_ctrl        = '0;
    load_use_stall = 1'b0;
    flush          = 1'b0;
    ex_ready       = 1'b1;
    model_reset();
    #2;
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    apply_stimulus("first", 1'b1, rand_meta(), 32'h100, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++)
      apply_stimulus("stream", 1'b1, rand_meta(), 32'(i * 4), 1'b0, 1'b0, 1'b1);

    apply_stimulus("lu_stall", 1'b1, rand_meta(), 32'h20, 1'b1, 1'b0, 1'b1);
    meta = rand_meta();
    meta[RS1_DATA_MSB -: 32] = 32'hDEADBEEF;
    apply_stimulus("lu_capture", 1'b1, meta, 32'h20, 1'b0, 1'b0, 1'b1);
    cmp("lu_rs1_data", 128'(ex_meta[RS1_DATA_MSB -: 32]), 128'(32'hDEADBEEF));

    apply_stimulus("hold_fill", 1'b1, rand_meta(), 32'h40, 1'b0, 1'b0, 1'b1);
    meta = rand_meta();
    for (int i = 0; i < 3; i++)
      apply_stimulus("hold", 1'b1, meta, 32'h44, 1'b0, 1'b0, 1'b0);
    apply_stimulus("hold_release", 1'b1, meta, 32'h44, 1'b0, 1'b0, 1'b1);

    apply_stimulus("flush_prio", 1'b1, rand_meta(), 32'h48, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a hold must discard everything
    apply_stimulus("pre_reset", 1'b1, rand_meta(), 32'h80, 1'b0, 1'b0, 1'b1);
    apply_stimulus("pre_reset_hold", 1'b1, rand_meta(), 32'h84, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 400; i++)
      apply_stimulus("random", 1'($urandom_range(0, 9) < 8), rand_meta(), $urandom(),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 9) < 7));

    do_reset();
    for (int i = 0; i < 20; i++)
      apply_stimulus("saturate", 1'b1, rand_meta(), 32'h200, 1'b1, 1'b0, 1'b1);
    cmp("bubble_sat", 128'(bubble_cnt), 128'(CNT_MAX));
    for (int i = 0; i < 20; i++)
      apply_stimulus("flush_sat", 1'b1, rand_meta(), 32'h300, 1'b0, 1'b1, 1'b1);
    cmp("flush_sat_final", 128'(flush_cnt), 128'(CNT_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
